gcd_lcm_stage: RTL
==================

// Module: gcd_lcm_stage
// PURPOSE
// - Downstream consumer of the 8-bit GCD engine: takes an operand pair {a,b} plus its GCD, produces LCM = (a/gcd)*b.
// - Sequential datapath (restoring divider, then shift-add multiplier); no combinational divide/multiply.
// - Valid/ready on both sides so it can be backpressured by whatever consumes the LCM.
// PARAMETERS
// - WIDTH  8  operand and GCD width; LCM result is 2*WIDTH bits
// PORTS
// - clk        in   1          single clock, all state on posedge
// - rst_n      in   1          asynchronous, active-low reset
// - in_valid   in   1          operand triple valid
// - in_ready   out  1          stage can accept (high only in IDLE)
// - in_a       in   WIDTH      operand a
// - in_b       in   WIDTH      operand b
// - in_gcd     in   WIDTH      gcd(a,b) from GCD engine
// - out_valid  out  1          out_lcm/err_zero valid
// - out_ready  in   1          downstream accepts result
// - out_lcm    out  2*WIDTH    LCM result
// - err_zero   out  1          in_gcd was 0; out_lcm forced to 0
// - busy       out  1          high in DIV, MUL, DONE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_lcm=0, err_zero=0, busy=0; internal regs cleared. Reset mid-operation aborts; the triple is lost.
// - Accept edge T: in_valid&&in_ready at posedge; a,b,gcd registered; in_ready drops next cycle.
// - FSM: IDLE -> (in_gcd==0 ? DONE : DIV) -> MUL -> DONE -> IDLE.
// - DIV: restoring division a/gcd, one quotient bit per cycle, MSB first, exactly WIDTH cycles; quotient q (WIDTH bits), remainder r.
// - MUL: shift-add q*b, one bit of q per cycle, exactly WIDTH cycles; 2*WIDTH-bit accumulator, no overflow possible.
// - Latency: normal path out_valid rises at edge T+2*WIDTH+1 (T+17 for WIDTH=8); gcd==0 path at T+1.
// - DONE: out_valid=1; out_lcm, err_zero held stable until out_valid&&out_ready; then IDLE next edge, out_valid=0.
// - out_lcm keeps last value after handshake (not cleared); err_zero cleared on next accept.
// - in_ready=0 in DONE even if out_ready=1 same cycle; new accept earliest the cycle after the output handshake.
// - a==0 or b==0 with gcd!=0: normal path, out_lcm=0, err_zero=0.
// - gcd not dividing a: no check (see CONFIGURATION); result is floor(a/gcd)*b.
// - Inputs ignored while in_ready=0; input changes after accept do not affect result.
// CONFIGURATION
// - LCM_REM_CHECK_EN defined: adds output err_rem (1 bit, reset 0); set in DONE when DIV remainder r!=0, held/cleared like err_zero; out_lcm still floor(a/gcd)*b.
// - LCM_REM_CHECK_EN undefined: no err_rem port, remainder discarded; all other timing identical.
// TESTING
// - a=12,b=18,gcd=6, out_ready=1 -> out_lcm=36, err_zero=0, out_valid exactly at T+17.
// - a=255,b=254,gcd=1 -> out_lcm=64770 (max-width product), no overflow.
// - a=0,b=0,gcd=0 -> out_lcm=0, err_zero=1, out_valid at T+1; next triple 4,6,2 -> 12, err_zero=0.
// - a=12,b=18,gcd=6 with out_ready low 5 cycles after out_valid -> out_lcm=36 held, in_ready=0 throughout, IDLE one edge after handshake.
// - rst_n pulsed low at T+4 (in DIV) -> outputs at reset values immediately, in_ready=1; next triple 9,6,3 -> 18.
// - LCM_REM_CHECK_EN: a=10,b=4,gcd=3 -> out_lcm=12, err_rem=1; a=10,b=4,gcd=2 -> 20, err_rem=0.

Source files
------------

// File: rtl/gcd_lcm_stage.sv
// LCM stage: out_lcm = floor(a/gcd)*b using a restoring divider followed by a shift-add multiplier.
// Optional remainder flag err_rem is built only when LCM_REM_CHECK_EN is defined.
module gcd_lcm_stage #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_gcd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_lcm,
  output logic               err_zero,
`ifdef LCM_REM_CHECK_EN
  output logic               err_rem,
`endif
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  // in_ready is high only in IDLE; the result is held in DONE until out_valid && out_ready.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     div_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   out_lcm_q;
  logic                 err_zero_q;
`ifdef LCM_REM_CHECK_EN
  logic                 err_rem_q;
`endif

  logic [WIDTH:0]       trial_d;
  logic [WIDTH:0]       diff_d;
  logic                 qbit_d;
  logic [WIDTH-1:0]     rem_d;
  logic [2*WIDTH-1:0]   acc_d;

  // One restoring-division step: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial_d = {rem_q, quo_q[WIDTH-1]};
    diff_d  = trial_d - {1'b0, div_q};
    qbit_d  = (trial_d >= {1'b0, div_q});
    rem_d   = qbit_d ? diff_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    acc_d   = quo_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_lcm_q   <= '0;
      err_zero_q  <= 1'b0;
`ifdef LCM_REM_CHECK_EN
      err_rem_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            quo_q      <= in_a;
            rem_q      <= '0;
            div_q      <= in_gcd;
            mcand_q    <= {{WIDTH{1'b0}}, in_b};
            acc_q      <= '0;
            cnt_q      <= '0;
            err_zero_q <= (in_gcd == '0);
`ifdef LCM_REM_CHECK_EN
            err_rem_q  <= 1'b0;
`endif
            state_q    <= (in_gcd == '0) ? S_DONE : S_DIV;
          end
        end
        S_DIV: begin
          quo_q <= {quo_q[WIDTH-2:0], qbit_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          // Quotient is consumed LSB first while the multiplicand walks left.
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          quo_q   <= quo_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_lcm_q   <= acc_q;
`ifdef LCM_REM_CHECK_EN
            err_rem_q   <= (rem_q != '0);
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_lcm   = out_lcm_q;
  assign err_zero  = err_zero_q;
`ifdef LCM_REM_CHECK_EN
  assign err_rem   = err_rem_q;
`endif
  assign dbg_state = state_q;

endmodule
